single_cycle_mips: RTL and testbench

// - Single-cycle 32-bit MIPS subset CPU: fetch, decode, execute, memory access and writeback all complete in one clk cycle.
// - Top level of the processor: contains PC register, instruction memory (instance imem), 32x32 register file, ALU and data memory (instance dmem).
// - No external bus. Programs are preloaded into imem.mem_data via $readmemh; results are inspected hierarchically in dmem.mem_data and PC.

---
 rtl/single_cycle_mips.sv | 225 ++++++++++++++++++++++
 tb/tb_single_cycle_mips.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/single_cycle_mips.sv
// Single-cycle MIPS32 subset core: PC, instruction ROM (imem), 32x32 register
// file, ALU and word-addressed data RAM (dmem), all resolved in one clock.
module single_cycle_mips #(
  parameter int unsigned IMEM_WORDS = 256,
  parameter int unsigned DMEM_WORDS = 256
) (
  input  logic clk,
  input  logic reset
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned NREG = 32;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_JR   = 6'h08;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  logic [XLEN-1:0] PC;
  logic [XLEN-1:0] pc_d;
  logic [XLEN-1:0] regs_q [0:NREG-1];

  logic [XLEN-1:0] instr;
  logic [5:0]      opcode;
  logic [4:0]      rs;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      shamt;
  logic [5:0]      funct;
  logic [15:0]     imm;
  logic [25:0]     target;

  logic [XLEN-1:0] rs_val;
  logic [XLEN-1:0] rt_val;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_z;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] br_target;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] dmem_rdata;

  logic            rf_we;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            mem_we;
  logic            is_load;
  logic            is_link;

  // Instruction ROM, loaded from outside before reset is released
  if (1'b1) begin : imem
    logic [XLEN-1:0] mem_data [0:IMEM_WORDS-1];
  end

  // Data RAM, written at the clock edge, never cleared by reset
  if (1'b1) begin : dmem
    logic [XLEN-1:0] mem_data [0:DMEM_WORDS-1];

    // Store port: byte offset bits are dropped, upper bits wrap
    always_ff @(posedge clk) begin
      if (mem_we) begin
        mem_data[alu_res[9:2]] <= rt_val;
      end
    end
  end

  assign instr      = imem.mem_data[PC[9:2]];
  assign dmem_rdata = dmem.mem_data[alu_res[9:2]];

  assign opcode = instr[31:26];
  assign rs     = instr[25:21];
  assign rt     = instr[20:16];
  assign rd     = instr[15:11];
  assign shamt  = instr[10:6];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  assign target = instr[25:0];

  assign rs_val    = (rs == 5'd0) ? '0 : regs_q[rs];
  assign rt_val    = (rt == 5'd0) ? '0 : regs_q[rt];
  assign imm_s     = {{16{imm[15]}}, imm};
  assign imm_z     = {16'h0000, imm};
  assign pc_plus4  = PC + 32'd4;
  assign br_target = pc_plus4 + {imm_s[29:0], 2'b00};

  // Decode, execute and next-PC selection
  always_comb begin
    alu_res  = '0;
    rf_we    = 1'b0;
    rf_waddr = rt;
    mem_we   = 1'b0;
    is_load  = 1'b0;
    is_link  = 1'b0;
    pc_d     = pc_plus4;

    case (opcode)
      OP_RTYPE: begin
        rf_waddr = rd;
        rf_we    = 1'b1;
        case (funct)
          F_SLL:          alu_res = rt_val << shamt;
          F_SRL:          alu_res = rt_val >> shamt;
          F_SRA:          alu_res = 32'($signed(rt_val) >>> shamt);
          F_ADD, F_ADDU:  alu_res = rs_val + rt_val;
          F_SUB, F_SUBU:  alu_res = rs_val - rt_val;
          F_AND:          alu_res = rs_val & rt_val;
          F_OR:           alu_res = rs_val | rt_val;
          F_XOR:          alu_res = rs_val ^ rt_val;
          F_NOR:          alu_res = ~(rs_val | rt_val);
          F_SLT:          alu_res = {31'd0, $signed(rs_val) < $signed(rt_val)};
          F_SLTU:         alu_res = {31'd0, rs_val < rt_val};
          F_JR: begin
            rf_we = 1'b0;
            pc_d  = rs_val;
          end
          default:        rf_we = 1'b0;
        endcase
      end
      OP_ADDI, OP_ADDIU: begin
        alu_res = rs_val + imm_s;
        rf_we   = 1'b1;
      end
      OP_SLTI: begin
        alu_res = {31'd0, $signed(rs_val) < $signed(imm_s)};
        rf_we   = 1'b1;
      end
      OP_SLTIU: begin
        alu_res = {31'd0, rs_val < imm_s};
        rf_we   = 1'b1;
      end
      OP_ANDI: begin
        alu_res = rs_val & imm_z;
        rf_we   = 1'b1;
      end
      OP_ORI: begin
        alu_res = rs_val | imm_z;
        rf_we   = 1'b1;
      end
      OP_XORI: begin
        alu_res = rs_val ^ imm_z;
        rf_we   = 1'b1;
      end
      OP_LUI: begin
        alu_res = {imm, 16'h0000};
        rf_we   = 1'b1;
      end
      OP_LW: begin
        alu_res = rs_val + imm_s;
        rf_we   = 1'b1;
        is_load = 1'b1;
      end
      OP_SW: begin
        alu_res = rs_val + imm_s;
        mem_we  = 1'b1;
      end
      OP_BEQ: begin
        if (rs_val == rt_val) pc_d = br_target;
      end
      OP_BNE: begin
        if (rs_val != rt_val) pc_d = br_target;
      end
      OP_J: begin
        pc_d = {pc_plus4[31:28], target, 2'b00};
      end
      OP_JAL: begin
        pc_d     = {pc_plus4[31:28], target, 2'b00};
        rf_we    = 1'b1;
        rf_waddr = 5'd31;
        is_link  = 1'b1;
      end
      default: ;
    endcase

    // $0 is hardwired to zero
    if (rf_waddr == 5'd0) rf_we = 1'b0;

    rf_wdata = is_load ? dmem_rdata : (is_link ? pc_plus4 : alu_res);
  end

  // Program counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      PC <= '0;
    end else begin
      PC <= pc_d;
    end
  end

  // Register file write port; all registers cleared on reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
    end else if (rf_we) begin
      regs_q[rf_waddr] <= rf_wdata;
    end
  end

endmodule

// File: tb/tb_single_cycle_mips.sv
// Bench for single_cycle_mips: loads small hand-assembled programs into imem,
// runs each to its self-jump halt and compares dmem words against a table.
module tb_single_cycle_mips;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          prog;
    int          word;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    int          word;
    logic [31:0] exp;
    string       name;
  } sb_t;

  vec_t        vecs[$];
  sb_t         sb[$];
  logic [31:0] prog[$];
  logic [31:0] pc_prev = 32'hFFFF_FFFF;

  single_cycle_mips dut (
    .clk   (clk),
    .reset (reset)
  );

  always #5 clk = ~clk;

  // PC trace
  always @(negedge clk) begin
    if (dut.PC !== pc_prev) begin
      $display("PC %h", dut.PC);
      pc_prev = dut.PC;
    end
  end

  // Global time bound
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(int f, int rs, int rt, int rd, int sh);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(f)};
  endfunction

  function automatic logic [31:0] enc_i(int op, int rs, int rt, int imm);
    return {6'(op), 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  function automatic logic [31:0] enc_j(int op, int tgt);
    return {6'(op), 26'(tgt)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_prog();
    for (int i = 0; i < 256; i++) dut.imem.mem_data[i] = 32'h0;
    foreach (prog[i]) dut.imem.mem_data[i] = prog[i];
  endtask

  // Reset, load, run to halt (optionally pulsing reset mid-run), then score dmem
  task automatic run_prog(input int id, input logic [31:0] halt_pc, input int rst_at);
    bit  done;
    sb_t e;
    @(negedge clk);
    reset = 1'b1;
    load_prog();
    @(negedge clk);
    reset = 1'b0;
    done = 1'b0;
    for (int n = 0; n < 300 && !done; n++) begin
      @(posedge clk);
      #1;
      if (n == rst_at) begin
        @(negedge clk);
        reset = 1'b1;
        #1;
        check($sformatf("p%0d_midreset_pc", id), dut.PC, 32'h0);
        check($sformatf("p%0d_midreset_r1", id), dut.regs_q[1], 32'h0);
        check($sformatf("p%0d_midreset_r2", id), dut.regs_q[2], 32'h0);
        @(negedge clk);
        reset = 1'b0;
      end else if (dut.PC == halt_pc) begin
        done = 1'b1;
      end
    end
    check($sformatf("p%0d_reach_halt", id), dut.PC, halt_pc);
    foreach (vecs[i]) begin
      if (vecs[i].prog == id) sb.push_back('{vecs[i].word, vecs[i].exp, vecs[i].name});
    end
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.name, dut.dmem.mem_data[e.word], e.exp);
    end
  endtask

  initial begin
    // Expected dmem contents per program
    vecs.push_back('{1, 50, 32'h0000_0002, "p1_add_neg"});
    vecs.push_back('{2, 51, 32'h0000_00FF, "p2_or"});
    vecs.push_back('{2, 52, 32'h0000_0000, "p2_and"});
    vecs.push_back('{2, 53, 32'h0000_0000, "p2_slt"});
    vecs.push_back('{2, 54, 32'h0000_0000, "p2_sltu_m1_1"});
    vecs.push_back('{3, 55, 32'hDEAD_BEEF, "p3_sw"});
    vecs.push_back('{3, 56, 32'hDEAD_BEEF, "p3_lw_sw"});
    vecs.push_back('{3, 0,  32'hDEAD_BEEF, "p3_wrap_store"});
    vecs.push_back('{3, 58, 32'hDEAD_BEEF, "p3_wrap_load"});
    vecs.push_back('{4, 57, 32'h0000_000F, "p4_loop_sum"});
    vecs.push_back('{4, 59, 32'h0000_0123, "p4_beq_skip"});
    vecs.push_back('{5, 60, 32'h0000_0008, "p5_jal_link"});
    vecs.push_back('{5, 61, 32'h0000_0055, "p5_r0_ignored"});
    vecs.push_back('{5, 62, 32'h0000_0077, "p5_subroutine"});
    vecs.push_back('{6, 63, 32'hF800_0000, "p6_sra"});
    vecs.push_back('{6, 64, 32'h0800_0000, "p6_srl"});
    vecs.push_back('{6, 65, 32'hC000_0000, "p6_sll"});
    vecs.push_back('{6, 66, 32'hFFFF_FFFD, "p6_sub"});
    vecs.push_back('{6, 67, 32'hFFFF_FFFC, "p6_nor"});
    vecs.push_back('{6, 68, 32'hFFFF_0002, "p6_xori"});
    vecs.push_back('{6, 69, 32'h0000_0001, "p6_slti"});
    vecs.push_back('{6, 70, 32'h0000_0001, "p6_sltiu"});
    vecs.push_back('{6, 71, 32'h0000_8000, "p6_andi_unkfunct"});
    vecs.push_back('{6, 72, 32'h7FFF_FFFF, "p6_addiu_unkop"});
    vecs.push_back('{6, 73, 32'h0000_0001, "p6_slt_signed"});
    vecs.push_back('{6, 74, 32'h7FFF_FFFD, "p6_xor"});
    vecs.push_back('{6, 75, 32'hFFFF_FFFA, "p6_subu"});
    vecs.push_back('{6, 76, 32'h8000_0002, "p6_addu_wrap"});

    // P1: addi/addi/add/sw
    prog = '{enc_i(8, 0, 1, 5), enc_i(8, 0, 2, -3), enc_r(32'h20, 1, 2, 3, 0),
             enc_i(32'h2B, 0, 3, 200), enc_j(2, 4)};

    // Reset held three cycles, first fetch right after release
    load_prog();
    repeat (3) begin
      @(posedge clk);
      #1;
      check("reset_pc", dut.PC, 32'h0);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check("pc_after_release", dut.PC, 32'h4);

    run_prog(1, 32'h10, -1);

    // P2: logic and compare
    prog = '{enc_i(32'h0D, 0, 1, 32'hF0), enc_i(32'h0D, 0, 2, 32'h0F),
             enc_r(32'h25, 1, 2, 3, 0), enc_r(32'h24, 1, 2, 4, 0),
             enc_r(32'h2A, 1, 2, 5, 0), enc_i(8, 0, 6, -1), enc_i(8, 0, 7, 1),
             enc_r(32'h2B, 6, 7, 8, 0),
             enc_i(32'h2B, 0, 3, 204), enc_i(32'h2B, 0, 4, 208),
             enc_i(32'h2B, 0, 5, 212), enc_i(32'h2B, 0, 8, 216), enc_j(2, 12)};
    run_prog(2, 32'h30, -1);

    // P3: lw/sw round trip and address wrap
    prog = '{enc_i(32'h0F, 0, 1, 32'hDEAD), enc_i(32'h0D, 1, 1, 32'hBEEF),
             enc_i(32'h2B, 0, 1, 220), enc_i(32'h23, 0, 2, 220),
             enc_i(32'h2B, 0, 2, 224), enc_i(32'h2B, 0, 1, 32'h402),
             enc_i(32'h23, 0, 3, 2), enc_i(32'h2B, 0, 3, 232), enc_j(2, 8)};
    run_prog(3, 32'h20, -1);

    // P4: bne loop and beq skip, with a reset pulse partway through
    prog = '{enc_i(8, 0, 1, 5), enc_i(8, 0, 2, 0), enc_r(32'h20, 2, 1, 2, 0),
             enc_i(8, 1, 1, -1), enc_i(5, 1, 0, -3), enc_i(32'h2B, 0, 2, 228),
             enc_i(8, 0, 4, 32'h123), enc_i(4, 0, 0, 1), enc_i(8, 0, 4, 32'hBAD),
             enc_i(32'h2B, 0, 4, 236), enc_j(2, 10)};
    run_prog(4, 32'h28, 3);

    // P5: jal / jr / j and writes to $0
    prog = '{enc_i(8, 0, 0, 7), enc_j(3, 6), enc_i(32'h2B, 0, 31, 240),
             enc_i(8, 0, 6, 32'h55), enc_r(32'h20, 6, 0, 6, 0), enc_j(2, 9),
             enc_i(8, 0, 7, 32'h77), enc_i(32'h2B, 0, 7, 248),
             enc_r(32'h08, 31, 0, 0, 0), enc_i(32'h2B, 0, 6, 244), enc_j(2, 10)};
    run_prog(5, 32'h28, -1);

    // P6: shifts, immediates, wrap-around, unknown opcode/funct
    prog = '{enc_i(32'h0F, 0, 1, 32'h8000), enc_r(32'h03, 0, 1, 2, 4),
             enc_r(32'h02, 0, 1, 3, 4), enc_i(8, 0, 4, 3), enc_r(32'h00, 0, 4, 5, 30),
             enc_r(32'h22, 0, 4, 6, 0), enc_r(32'h27, 4, 0, 7, 0),
             enc_i(32'h0E, 6, 8, 32'hFFFF), enc_i(32'h0A, 6, 9, -2),
             enc_i(32'h0B, 4, 10, -1), enc_i(32'h0C, 6, 11, 32'h8000),
             enc_i(32'h09, 1, 12, -1), enc_i(32'h3F, 0, 12, 32'h1234),
             enc_r(32'h3F, 4, 4, 11, 0), enc_r(32'h2A, 6, 4, 13, 0),
             enc_r(32'h26, 1, 6, 14, 0), enc_r(32'h23, 6, 4, 15, 0),
             enc_r(32'h21, 12, 4, 16, 0)};
    begin
      int st_regs[14] = '{2, 3, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15, 16};
      for (int k = 0; k < 14; k++) prog.push_back(enc_i(32'h2B, 0, st_regs[k], 252 + 4 * k));
    end
    prog.push_back(enc_j(2, 32'h20));
    run_prog(6, 32'h80, -1);

    // Data memory survives the resets between programs
    check("dmem_retained_w50", dut.dmem.mem_data[50], 32'h0000_0002);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
